// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
//   state_t      : control-step state (IDLE, T0..T6)
//   OP_*         : register-register ALU opcodes
//   *_HI/*_LO    : IR field bit positions
//   is_alu_op()  : opcode is one of the ALU ops this sequencer executes
//   is_mul_div() : opcode produces a 64-bit result (LO then HI write-back)
package alu_seq_pkg;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam int OP_W  = 5;
  localparam int IDX_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00010;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00011;
  localparam logic [OP_W-1:0] OP_AND = 5'b00100;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL = 5'b01001;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01010;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01011;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  // ALU opcodes form the contiguous range ADD..DIV.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_DIV);
  endfunction

  function automatic logic is_mul_div(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_reg_sel_decoder.sv
// Register index to one-hot select.
//   i_idx : 4-bit register index
//   i_en  : when low the output is all zeros
//   o_sel : one-hot NUM_REGS-wide select (zero if the index is out of range)
module reg_sel_decoder
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_sel
);

  assign o_sel = i_en ? (NUM_REGS'(1) << i_idx) : '0;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for one fetch (T0-T2) and one register-register ALU
// instruction (T3-T5, plus T6 for MUL/DIV). It drives the Datapath strobes.
// All outputs are registered and decoded from the next state, so every
// strobe is aligned with the state it belongs to and no input reaches an
// output combinationally.
//   clock, clear      : rising-edge clock, async active-low reset
//   start             : launch one instruction (sampled only in IDLE)
//   mem_ready         : memory data valid, qualifies the T1 read
//   ir                : instruction register contents
//   PCout..LOin       : Datapath strobes
//   R_out / R_in      : one-hot register bus drive / register load
//   opcode            : ALU operation select (non-zero in T4 only)
//   busy/done/illegal : status (done and illegal are one-cycle pulses)
// Optional: `define ALU_SEQ_PERF_EN adds instr_count and stall_count.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] R_out,
  output logic [NUM_REGS-1:0] R_in,
  output logic [OPC_W-1:0]    opcode,
  output logic                busy,
  output logic                done,
  output logic                illegal
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
`endif
);

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [IDX_W-1:0] r_ra, r_rc;

  state_t                w_nxt;
  logic                  w_ack, w_done, w_ill;
  logic [IDX_W-1:0]      w_out_idx;
  logic                  w_out_en, w_in_en;
  logic [NUM_REGS-1:0]   w_out_sel, w_in_sel;
  logic                  w_unused;

  assign w_unused = &{1'b0, ir[RC_LO-1:0]};

  always_comb begin
    w_nxt = r_state;
    w_ill = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_nxt = T0;
      T0:   w_nxt = T1;
      // PCin marks the T1 cycle that completed the read; leave after it.
      T1:   if (PCin) w_nxt = T2;
      T2: begin
        if (is_alu_op(ir[OP_HI:OP_LO])) w_nxt = T3;
        else begin
          w_nxt = IDLE;
          w_ill = 1'b1;
        end
      end
      T3:   w_nxt = T4;
      T4:   w_nxt = T5;
      T5:   w_nxt = is_mul_div(r_op) ? T6 : IDLE;
      T6:   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // mem_ready is sampled on the edge that opens each T1 cycle so the T1
  // strobes stay registered: a cycle opened with mem_ready low is a wait
  // cycle (Read only), the one opened with mem_ready high is the exit cycle.
  assign w_ack  = (w_nxt == T1) && mem_ready;
  assign w_done = (w_nxt == IDLE) && ((r_state == T5) || (r_state == T6));

  // Rb is taken straight from ir when entering T3 because the field
  // register loads on that same edge.
  assign w_out_idx = (w_nxt == T3) ? ir[RB_HI:RB_LO] : r_rc;
  assign w_out_en  = (w_nxt == T3) || (w_nxt == T4);
  assign w_in_en   = (w_nxt == T5) && !is_mul_div(r_op);

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_out_sel (
    .i_idx (w_out_idx),
    .i_en  (w_out_en),
    .o_sel (w_out_sel)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_in_sel (
    .i_idx (r_ra),
    .i_en  (w_in_en),
    .o_sel (w_in_sel)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_ra     <= '0;
      r_rc     <= '0;
      PCout    <= 1'b0;
      MARin    <= 1'b0;
      IncPC    <= 1'b0;
      Zin      <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      PCin     <= 1'b0;
      Read     <= 1'b0;
      MDRin    <= 1'b0;
      MDRout   <= 1'b0;
      IRin     <= 1'b0;
      Yin      <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      R_out    <= '0;
      R_in     <= '0;
      opcode   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == T2) && (w_nxt == T3)) begin
        r_op <= ir[OP_HI:OP_LO];
        r_ra <= ir[RA_HI:RA_LO];
        r_rc <= ir[RC_HI:RC_LO];
      end
      PCout    <= (w_nxt == T0);
      MARin    <= (w_nxt == T0);
      IncPC    <= (w_nxt == T0);
      Zin      <= (w_nxt == T0) || (w_nxt == T4);
      Zlowout  <= w_ack || (w_nxt == T5);
      Zhighout <= (w_nxt == T6);
      PCin     <= w_ack;
      Read     <= (w_nxt == T1);
      MDRin    <= w_ack;
      MDRout   <= (w_nxt == T2);
      IRin     <= (w_nxt == T2);
      Yin      <= (w_nxt == T3);
      HIin     <= (w_nxt == T6);
      LOin     <= (w_nxt == T5) && is_mul_div(r_op);
      R_out    <= w_out_sel;
      R_in     <= w_in_sel;
      opcode   <= (w_nxt == T4) ? OPC_W'(r_op) : '0;
      busy     <= (w_nxt != IDLE);
      done     <= w_done;
      illegal  <= w_ill;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_done) instr_count <= instr_count + 32'd1;
      if ((w_nxt == T1) && !mem_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
